// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pin and key-event bundle between the scanner and its surroundings
interface keypad_scanner_if #(
    parameter int NROWS = 4,
    parameter int NCOLS = 4
);
    localparam int KW = $clog2(NROWS * NCOLS);

    logic [NROWS-1:0] rows;
    logic [NCOLS-1:0] cols;
    logic [KW-1:0]    key_code;
    logic             key_valid;
    logic             key_held;

    modport master (
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad column scanner with synchronised, debounced press/release detection
module keypad_scanner #(
    parameter int NROWS    = 4,
    parameter int NCOLS    = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    keypad_scanner_if.master   bus
);
    localparam int KW   = $clog2(NROWS * NCOLS);
    localparam int CW   = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int RW   = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNTW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NROWS-1:0] sync1_q, sync2_q;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_cap_q, row_cap_d;
    logic [CNTW-1:0]  db_q, db_d;
    logic [CNTW-1:0]  rel_q, rel_d;
    logic [KW-1:0]    key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             last;
    logic             single;
    logic [RW-1:0]    row_idx;
    logic [CW-1:0]    col_next;
    logic [CNTW-1:0]  db_inc, rel_inc;
    logic             same_single;
    logic             cap_high;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SCAN;
            sync1_q     <= '1;
            sync2_q     <= '1;
            dwell_q     <= '0;
            col_q       <= '0;
            row_cap_q   <= '0;
            db_q        <= '0;
            rel_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bus.rows;
            sync2_q     <= sync1_q;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            row_cap_q   <= row_cap_d;
            db_q        <= db_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Rows are active-low: a usable sample has exactly one row pulled down.
    always_comb begin
        row_idx = '0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (!sync2_q[i]) row_idx = RW'(i);
        end
    end

    assign last        = (dwell_q == DW'(SCAN_DIV - 1));
    assign single      = $onehot(~sync2_q);
    assign col_next    = (col_q == CW'(NCOLS - 1)) ? '0 : col_q + 1'b1;
    assign db_inc      = (db_q == CNTW'(DEBOUNCE)) ? db_q : db_q + 1'b1;
    assign rel_inc     = (rel_q == CNTW'(DEBOUNCE)) ? rel_q : rel_q + 1'b1;
    assign same_single = (sync2_q == ~(NROWS'(1) << row_cap_q));
    assign cap_high    = sync2_q[row_cap_q];

    always_comb begin
        state_d     = state_q;
        dwell_d     = last ? '0 : dwell_q + 1'b1;
        col_d       = col_q;
        row_cap_d   = row_cap_q;
        db_d        = db_q;
        rel_d       = rel_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (last) begin
            unique case (state_q)
                S_SCAN: begin
                    if (single) begin
                        row_cap_d = row_idx;
                        db_d      = CNTW'(1);
                        if (DEBOUNCE <= 1) begin
                            key_valid_d = 1'b1;
                            key_code_d  = KW'(row_idx) * KW'(NCOLS) + KW'(col_q);
                            key_held_d  = 1'b1;
                            state_d     = S_HELD;
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                S_DEBOUNCE: begin
                    if (same_single) begin
                        db_d = db_inc;
                        if (db_inc == CNTW'(DEBOUNCE)) begin
                            key_valid_d = 1'b1;
                            key_code_d  = KW'(row_cap_q) * KW'(NCOLS) + KW'(col_q);
                            key_held_d  = 1'b1;
                            state_d     = S_HELD;
                        end
                    end else begin
                        db_d    = '0;
                        col_d   = col_next;
                        state_d = S_SCAN;
                    end
                end
                S_HELD: begin
                    // Extra rows in the held column are ignored while the captured row is down.
                    if (cap_high) begin
                        db_d  = '0;
                        rel_d = CNTW'(1);
                        if (DEBOUNCE <= 1) begin
                            key_held_d = 1'b0;
                            col_d      = col_next;
                            state_d    = S_SCAN;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (cap_high) begin
                        rel_d = rel_inc;
                        if (rel_inc == CNTW'(DEBOUNCE)) begin
                            key_held_d = 1'b0;
                            col_d      = col_next;
                            state_d    = S_SCAN;
                        end
                    end else begin
                        rel_d   = '0;
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

    assign bus.cols      = ~(NCOLS'(1) << col_q);
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;
endmodule
